// File: rtl/pixel_bus_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pixel_bus_scheduler
//   Shares the edge detector's single AHB master port between the input pixel
//   fetch buffer (reads) and the output result buffer (writes). After a start
//   pulse it generates word addresses from the latched bases, arbitrates one
//   transfer at a time, counts words per class and pulses frame_done once both
//   classes have moved num_words words.
//
//   Optional feature macro: SCHED_WRITE_PRIO_EN
//     defined   -> strict write priority in ARB
//     undefined -> round-robin between read and write (default)
//
// Ports
//   clk, n_rst              clock, asynchronous active-low reset
//   start                   one-cycle kickstart (honoured in IDLE only)
//   rd_base, wr_base        source / destination image base addresses
//   num_words               words per frame, shared by read and write
//   rd_req / rd_ack         fetch buffer has space / read word transferred
//   wr_req / wr_ack         result buffer has a word / write word transferred
//   bus_req, bus_write,     transfer request, direction (1 = write) and word
//   bus_addr                address toward the AHB master
//   bus_done                one-cycle transfer-complete pulse from the master
//   busy                    frame in progress
//   frame_done              one-cycle pulse: all words read and written
// -----------------------------------------------------------------------------
module pixel_bus_scheduler #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic              rd_ack,
  output logic              wr_ack,
  output logic              bus_req,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_done,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // word alignment: byte offset bits are forced to zero when latching bases
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_rd_base;
  logic [ADDR_W-1:0]   r_wr_base;
  logic [CNT_W-1:0]    r_num;
  logic [CNT_W-1:0]    r_rd_cnt;
  logic [CNT_W-1:0]    r_wr_cnt;
  logic                r_last_wr;   // last served class: 1 = WRITE, 0 = READ

  logic                w_rd_elig;
  logic                w_wr_elig;
  logic                w_pick_wr;
  logic                w_all_done;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [ADDR_W-1:0]   w_wr_addr;

  // counters never pass r_num, so eligibility alone saturates them
  assign w_rd_elig  = rd_req & (r_rd_cnt < r_num);
  assign w_wr_elig  = wr_req & (r_wr_cnt < r_num);
  assign w_all_done = (r_rd_cnt == r_num) & (r_wr_cnt == r_num);

`ifdef SCHED_WRITE_PRIO_EN
  // drain the result buffer first; r_last_wr is tracked but unused here
  assign w_pick_wr = w_wr_elig;
`else
  // under contention serve the class opposite the one served last
  assign w_pick_wr = w_wr_elig & (~w_rd_elig | ~r_last_wr);
`endif

  // word index -> byte offset; the add wraps modulo 2^ADDR_W
  assign w_rd_addr = r_rd_base + ADDR_W'({r_rd_cnt, 2'b00});
  assign w_wr_addr = r_wr_base + ADDR_W'({r_wr_cnt, 2'b00});

  // ---------------------------------------------------------------------------
  // state register and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_rd_base <= '0;
      r_wr_base <= '0;
      r_num     <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_last_wr <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rd_base <= rd_base & ALIGN_MASK;
            r_wr_base <= wr_base & ALIGN_MASK;
            r_num     <= num_words;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
          end
        end
        S_READ: begin
          if (bus_done) begin
            r_rd_cnt  <= r_rd_cnt + 1'b1;
            r_last_wr <= 1'b0;
          end
        end
        S_WRITE: begin
          if (bus_done) begin
            r_wr_cnt  <= r_wr_cnt + 1'b1;
            r_last_wr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // next state and outputs; bus outputs are decoded from registered state so
  // they stay stable for the whole transfer
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    rd_ack      = 1'b0;
    wr_ack      = 1'b0;
    bus_req     = 1'b0;
    bus_write   = 1'b0;
    bus_addr    = '0;
    frame_done  = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (num_words == '0) ? S_DONE : S_ARB;
      end
      S_ARB: begin
        if (w_all_done)     w_state_nxt = S_DONE;
        else if (w_pick_wr) w_state_nxt = S_WRITE;
        else if (w_rd_elig) w_state_nxt = S_READ;
      end
      S_READ: begin
        bus_req  = 1'b1;
        bus_addr = w_rd_addr;
        if (bus_done) begin
          rd_ack      = 1'b1;
          w_state_nxt = S_ARB;
        end
      end
      S_WRITE: begin
        bus_req   = 1'b1;
        bus_write = 1'b1;
        bus_addr  = w_wr_addr;
        if (bus_done) begin
          wr_ack      = 1'b1;
          w_state_nxt = S_ARB;
        end
      end
      S_DONE: begin
        frame_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
